// File: rtl/ni_buffer_pkg.sv
// Shared flit-type encodings, tail detection and default sizing for the NI buffers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef FTYPEWD
`define FTYPEWD 2
`endif

package ni_buffer_pkg;

  // Width of the flit type field carried in the flit MSBs
  localparam int FTYPE_W = `FTYPEWD;

  // Flit type encodings; tail and single both close a packet
  typedef enum logic [FTYPE_W-1:0] {
    FTYPE_BODY   = 2'b00,
    FTYPE_TAIL   = 2'b01,
    FTYPE_HEAD   = 2'b10,
    FTYPE_SINGLE = 2'b11
  } ftype_t;

  // Default sizing for the request output buffer
  localparam int DEF_FLIT_WIDTH  = 32;
  localparam int DEF_LOG_DEPTH   = 2;
  localparam int DEF_NUM_CREDITS = 2;
  localparam int DEF_CREDITWD    = 3;

  // True when the type field marks the last flit of a packet
  function automatic logic is_tail(input logic [FTYPE_W-1:0] ftype);
    return (ftype == FTYPE_TAIL) || (ftype == FTYPE_SINGLE);
  endfunction

endpackage

// File: rtl/ni_request_output_buffer_if.sv
// Flit bundle between the NI request path, the output buffer and the first switch port.
// Latency: n/a (wiring only).
// Backpressure: stall towards the NI, credit_in from the switch.
interface ni_request_output_buffer_if #(
  parameter int FLIT_WIDTH = ni_buffer_pkg::DEF_FLIT_WIDTH
);

  logic                  valid_in;
  logic [FLIT_WIDTH-1:0] flit_in;
  logic                  stall;
  logic                  valid_out;
  logic [FLIT_WIDTH-1:0] flit_out;
  logic                  credit_in;
  logic                  credit_err;

  // Environment side: NI drives flits in, switch returns credits
  modport master (
    output valid_in, flit_in, credit_in,
    input  stall, valid_out, flit_out, credit_err
  );

  // Buffer side
  modport slave (
    input  valid_in, flit_in, credit_in,
    output stall, valid_out, flit_out, credit_err
  );

endinterface

// File: rtl/ni_credit_counter.sv
// Downstream credit tracker: counts free slots in the switch input buffer.
// Latency: count updates one cycle after dec/inc; has_credit is combinational from the count.
// Backpressure: has_credit low blocks pops; a surplus credit saturates and raises sticky credit_err.
module ni_credit_counter #(
  parameter int NUM_CREDITS = ni_buffer_pkg::DEF_NUM_CREDITS,
  parameter int CREDITWD    = ni_buffer_pkg::DEF_CREDITWD
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic has_credit,
  output logic credit_err
);

  localparam logic [CREDITWD-1:0] MAX_CREDITS = CREDITWD'(NUM_CREDITS);

  logic [CREDITWD-1:0] count;

  assign has_credit = (count != '0);

  // Credit count: simultaneous inc and dec cancel; a credit beyond the maximum is an error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= MAX_CREDITS;
      credit_err <= 1'b0;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end else if (inc && !dec) begin
      if (count == MAX_CREDITS) begin
        credit_err <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ni_request_output_buffer.sv
// Flit FIFO from the NI request path to the first switch; store-and-forward under NI_OUT_BUF_STORE_FWD_EN.
// Latency: 2 cycles push-to-flit_out when empty with credits (head at N+1, registered output at N+2).
// Backpressure: stall = FIFO full (NI holds the flit); pops wait for a downstream credit.
module ni_request_output_buffer
  import ni_buffer_pkg::*;
#(
  parameter int FLIT_WIDTH  = DEF_FLIT_WIDTH,
  parameter int LOG_DEPTH   = DEF_LOG_DEPTH,
  parameter int NUM_CREDITS = DEF_NUM_CREDITS,
  parameter int CREDITWD    = DEF_CREDITWD
) (
  input  logic                        clk,
  input  logic                        rst,
  ni_request_output_buffer_if.slave   bus
);

  localparam int                 DEPTH    = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH+1)'(DEPTH);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr;
  logic [LOG_DEPTH-1:0]  rd_ptr;
  logic [LOG_DEPTH:0]    count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  pop_ok;
  logic                  has_credit;
  logic [FLIT_WIDTH-1:0] head;
  logic                  valid_q;
  logic [FLIT_WIDTH-1:0] flit_q;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Stall follows the registered occupancy only, so a pop in the same cycle never frees a slot early
  assign push = bus.valid_in && !full;
  // A flit pushed this cycle is not yet counted, so it can never be popped in the same cycle
  assign pop  = !empty && has_credit && pop_ok;

  assign bus.stall     = full;
  assign bus.valid_out = valid_q;
  assign bus.flit_out  = flit_q;

  // Storage array: data only, validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.flit_in;
    end
  end

  // Pointers and occupancy; a reset drops everything buffered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered output stage; flit_out keeps its last value between flits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      flit_q  <= '0;
    end else begin
      valid_q <= pop;
      if (pop) begin
        flit_q <= head;
      end
    end
  end

`ifdef NI_OUT_BUF_STORE_FWD_EN
  logic [LOG_DEPTH:0] tails;
  logic               mid_packet;
  logic               push_tail;
  logic               pop_tail;

  assign push_tail = push && is_tail(bus.flit_in[FLIT_WIDTH-1 -: `FTYPEWD]);
  assign pop_tail  = pop  && is_tail(head[FLIT_WIDTH-1 -: `FTYPEWD]);

  // Start a packet only once its tail is buffered; finish a started packet regardless;
  // a full FIFO with no tail means the packet is longer than the buffer, so let it stream
  assign pop_ok = (tails != '0) || mid_packet || (full && (tails == '0));

  // Number of complete packets (tails) currently stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tails <= '0;
    end else begin
      case ({push_tail, pop_tail})
        2'b10:   tails <= tails + 1'b1;
        2'b01:   tails <= tails - 1'b1;
        default: tails <= tails;
      endcase
    end
  end

  // Tracks whether the switch has seen the start of a packet but not its tail
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mid_packet <= 1'b0;
    end else if (pop) begin
      mid_packet <= !pop_tail;
    end
  end
`else
  // Cut-through: any buffered flit may leave as soon as a credit is available
  assign pop_ok = 1'b1;
`endif

  ni_credit_counter #(
    .NUM_CREDITS (NUM_CREDITS),
    .CREDITWD    (CREDITWD)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .dec        (pop),
    .inc        (bus.credit_in),
    .has_credit (has_credit),
    .credit_err (bus.credit_err)
  );

endmodule
